// File: rtl/icon_pkg.sv
// Shared definitions for the icon compositor: Iconinfo field layout, the
// transparent colour code and a width helper.
package icon_pkg;

  // Iconinfo per channel is {enable, transpose, mirror_y, mirror_x, img_sel}.
  // IMG is the bit offset of img_sel; flags are offsets above the top of img_sel.
  localparam int unsigned INFO_IMG   = 0;
  localparam int unsigned INFO_MX    = 0;
  localparam int unsigned INFO_MY    = 1;
  localparam int unsigned INFO_TR    = 2;
  localparam int unsigned INFO_EN    = 3;
  localparam int unsigned INFO_FLAGS = 4;

  localparam int unsigned TRANSPARENT = 0;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/icon_addr_gen.sv
// Per-channel stage 1: window check against the icon origin, orientation
// transform and the registered ROM address / hit flag.
module icon_addr_gen
  import icon_pkg::*;
#(
  parameter int unsigned DIM_LOG2  = 4,
  parameter int unsigned LOC_W     = 8,
  parameter int unsigned LOC_SHIFT = 0,
  parameter int unsigned PIX_W     = 10,
  parameter int unsigned IMG_W     = 4,
  localparam int unsigned ROM_AW   = IMG_W + 2 * DIM_LOG2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [LOC_W-1:0]          loc_x_i,
  input  logic [LOC_W-1:0]          loc_y_i,
  input  logic [IMG_W+INFO_FLAGS-1:0] info_i,
  input  logic [PIX_W-1:0]          row_i,
  input  logic [PIX_W-1:0]          col_i,
  input  logic                      pix_valid_i,
  output logic [ROM_AW-1:0]         rom_addr_o,
  output logic                      hit_o
);

  localparam int unsigned PosW  = LOC_W + LOC_SHIFT;
  // One spare bit above both operands so a negative offset never aliases into the window.
  localparam int unsigned DiffW = ((PIX_W > PosW) ? PIX_W : PosW) + 1;

  logic [DiffW-1:0]    dr, dc;
  logic [DIM_LOG2-1:0] r, c, r_t, c_t;
  logic [IMG_W-1:0]    img;
  logic                en, tr, my, mx;
  logic                hit_d, hit_q;
  logic [ROM_AW-1:0]   addr_d, addr_q;

  assign img = info_i[INFO_IMG +: IMG_W];
  assign mx  = info_i[IMG_W + INFO_MX];
  assign my  = info_i[IMG_W + INFO_MY];
  assign tr  = info_i[IMG_W + INFO_TR];
  assign en  = info_i[IMG_W + INFO_EN];

  always_comb begin
    dr    = DiffW'(row_i) - (DiffW'(loc_y_i) << LOC_SHIFT);
    dc    = DiffW'(col_i) - (DiffW'(loc_x_i) << LOC_SHIFT);
    hit_d = en & pix_valid_i & ((dr >> DIM_LOG2) == '0) & ((dc >> DIM_LOG2) == '0);
    r     = dr[DIM_LOG2-1:0];
    c     = dc[DIM_LOG2-1:0];
    if (mx) c = ~c;
    if (my) r = ~r;
    if (tr) begin
      r_t = c;
      c_t = r;
    end else begin
      r_t = r;
      c_t = c;
    end
    addr_d = {img, r_t, c_t};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      hit_q <= hit_d;
      // Address only moves on a hit so idle ROMs see no toggling.
      if (hit_d) addr_q <= addr_d;
    end
  end

  assign rom_addr_o = addr_q;
  assign hit_o      = hit_q;

endmodule

// File: rtl/icon_compositor.sv
// Multi-icon overlay for the VGA raster: frame-synchronous position registers,
// per-channel address generators and a fixed-priority colour resolver (3-cycle pipeline).
module icon_compositor
  import icon_pkg::*;
#(
  parameter int unsigned NUM_ICONS = 4,
  parameter int unsigned DIM_LOG2  = 4,
  parameter int unsigned LOC_W     = 8,
  parameter int unsigned LOC_SHIFT = 0,
  parameter int unsigned PIX_W     = 10,
  parameter int unsigned IMG_W     = 4,
  parameter int unsigned COLOR_W   = 2,
  localparam int unsigned ROM_AW   = IMG_W + 2 * DIM_LOG2,
  localparam int unsigned ID_W     = clog2_min1(NUM_ICONS),
  localparam int unsigned INFO_W   = IMG_W + INFO_FLAGS
) (
  input  logic                         vga_clock,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic [NUM_ICONS*LOC_W-1:0]   LocX,
  input  logic [NUM_ICONS*LOC_W-1:0]   LocY,
  input  logic [NUM_ICONS*INFO_W-1:0]  Iconinfo,
  input  logic [PIX_W-1:0]             Rowpx,
  input  logic [PIX_W-1:0]             Colpx,
  input  logic                         pix_valid,
  output logic [NUM_ICONS*ROM_AW-1:0]  rom_addr,
  input  logic [NUM_ICONS*COLOR_W-1:0] rom_data,
  output logic [COLOR_W-1:0]           icon,
  output logic [ID_W-1:0]              icon_id,
  output logic                         icon_valid
);

  logic [NUM_ICONS*LOC_W-1:0]  loc_x_q, loc_y_q;
  logic [NUM_ICONS*INFO_W-1:0] info_q;
  logic [NUM_ICONS-1:0]        hit1, hit2_q;
  logic                        valid1_q, valid2_q, icon_valid_q;
  logic [COLOR_W-1:0]          icon_d, icon_q;
  logic [ID_W-1:0]             id_d, id_q;

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      loc_x_q      <= '0;
      loc_y_q      <= '0;
      info_q       <= '0;
      hit2_q       <= '0;
      valid1_q     <= 1'b0;
      valid2_q     <= 1'b0;
      icon_q       <= '0;
      id_q         <= '0;
      icon_valid_q <= 1'b0;
    end else begin
      if (frame_start) begin
        loc_x_q <= LocX;
        loc_y_q <= LocY;
        info_q  <= Iconinfo;
      end
      hit2_q       <= hit1;
      valid1_q     <= pix_valid;
      valid2_q     <= valid1_q;
      icon_q       <= icon_d;
      id_q         <= id_d;
      icon_valid_q <= valid2_q;
    end
  end

  for (genvar i = 0; i < NUM_ICONS; i++) begin : g_chan
    icon_addr_gen #(
      .DIM_LOG2 (DIM_LOG2),
      .LOC_W    (LOC_W),
      .LOC_SHIFT(LOC_SHIFT),
      .PIX_W    (PIX_W),
      .IMG_W    (IMG_W)
    ) u_addr_gen (
      .clk_i      (vga_clock),
      .rst_ni     (reset),
      .loc_x_i    (loc_x_q[i*LOC_W +: LOC_W]),
      .loc_y_i    (loc_y_q[i*LOC_W +: LOC_W]),
      .info_i     (info_q[i*INFO_W +: INFO_W]),
      .row_i      (Rowpx),
      .col_i      (Colpx),
      .pix_valid_i(pix_valid),
      .rom_addr_o (rom_addr[i*ROM_AW +: ROM_AW]),
      .hit_o      (hit1[i])
    );
  end

  // Scan from lowest priority upward so the lowest opaque channel wins.
  always_comb begin
    icon_d = COLOR_W'(TRANSPARENT);
    id_d   = '0;
    for (int i = NUM_ICONS - 1; i >= 0; i--) begin
      if (hit2_q[i] && (rom_data[i*COLOR_W +: COLOR_W] != COLOR_W'(TRANSPARENT))) begin
        icon_d = rom_data[i*COLOR_W +: COLOR_W];
        id_d   = ID_W'(i);
      end
    end
  end

  assign icon       = icon_q;
  assign icon_id    = id_q;
  assign icon_valid = icon_valid_q;

endmodule

// File: tb/tb_icon_compositor.sv
// Directed scoreboard bench for icon_compositor: a default-parameter DUT with a
// 1-cycle ROM model, plus a LOC_SHIFT=2 DUT for right-edge clipping.
module tb_icon_compositor;

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic [31:0] loc_x, loc_y, info;
  logic [9:0]  rowpx, colpx;
  logic        pix_valid;
  logic [47:0] rom_addr, rom_addr2;
  logic [7:0]  rom_data;
  logic [7:0]  rom_data2;
  logic [1:0]  icon, icon_id, icon2, icon_id2;
  logic        icon_valid, icon_valid2;

  logic [3:0]  rom_mode;
  logic [1:0]  rom_const [4];

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         chk;
    bit         chk2;
    logic [1:0] icon;
    logic [1:0] id;
    logic       vld;
    logic [1:0] icon2;
    logic       vld2;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  logic [7:0]  t2_info [5] = '{8'h85, 8'h95, 8'hA5, 8'hC5, 8'hF5};
  logic [11:0] t2_addr [5] = '{12'h512, 12'h51D, 12'h5E2, 12'h521, 12'h5DE};
  logic [1:0]  t2_icon [5] = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
  logic [11:0] prev_addr;

  icon_compositor u_dut (
    .vga_clock  (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .LocX       (loc_x),
    .LocY       (loc_y),
    .Iconinfo   (info),
    .Rowpx      (rowpx),
    .Colpx      (colpx),
    .pix_valid  (pix_valid),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .icon       (icon),
    .icon_id    (icon_id),
    .icon_valid (icon_valid)
  );

  icon_compositor #(.LOC_SHIFT(2)) u_dut_s2 (
    .vga_clock  (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .LocX       (loc_x),
    .LocY       (loc_y),
    .Iconinfo   (info),
    .Rowpx      (rowpx),
    .Colpx      (colpx),
    .pix_valid  (pix_valid),
    .rom_addr   (rom_addr2),
    .rom_data   (rom_data2),
    .icon       (icon2),
    .icon_id    (icon_id2),
    .icon_valid (icon_valid2)
  );

  assign rom_data2 = 8'h55;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      rom_data[i*2 +: 2] <= rom_mode[i] ? rom_addr[i*12 +: 2] : rom_const[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [7:0] lx, input logic [7:0] ly,
                        input logic [7:0] inf);
    loc_x[ch*8 +: 8] = lx;
    loc_y[ch*8 +: 8] = ly;
    info[ch*8 +: 8]  = inf;
  endtask

  task automatic pix(input logic [9:0] r, input logic [9:0] c, input logic v);
    rowpx     = r;
    colpx     = c;
    pix_valid = v;
  endtask

  // Push the expectation for the pixel currently driven, clock once, and
  // compare the output belonging to the pixel driven three edges ago.
  task automatic cyc(input string tag, input logic [1:0] ei, input logic [1:0] eid,
                     input logic ev, input bit c2, input logic [1:0] ei2, input logic ev2);
    exp_t e;
    e.chk = 1'b1; e.chk2 = c2; e.icon = ei; e.id = eid; e.vld = ev;
    e.icon2 = ei2; e.vld2 = ev2; e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      check({e.tag, "/icon"}, 64'(icon), 64'(e.icon));
      check({e.tag, "/id"}, 64'(icon_id), 64'(e.id));
      check({e.tag, "/valid"}, 64'(icon_valid), 64'(e.vld));
      if (e.chk2) begin
        check({e.tag, "/icon_s2"}, 64'(icon2), 64'(e.icon2));
        check({e.tag, "/valid_s2"}, 64'(icon_valid2), 64'(e.vld2));
      end
    end
  endtask

  task automatic cyc1(input string tag, input logic [1:0] ei, input logic [1:0] eid,
                      input logic ev);
    cyc(tag, ei, eid, ev, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; frame_start = 1'b0;
    loc_x = '0; loc_y = '0; info = '0;
    rowpx = '0; colpx = '0; pix_valid = 1'b0;
    rom_mode = '0;
    for (int i = 0; i < 4; i++) rom_const[i] = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_icon", 64'(icon), 64'd0);
    check("rst_id", 64'(icon_id), 64'd0);
    check("rst_valid", 64'(icon_valid), 64'd0);
    check("rst_addr", 64'(rom_addr), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single icon at (row 20, col 10), constant colour 1
    set_ch(0, 8'd10, 8'd20, 8'h80);
    rom_const[0] = 2'd1;
    frame_start = 1'b1; pix(0, 0, 0); cyc1("t1_load", 0, 0, 0);
    frame_start = 1'b0;
    pix(20, 10, 1); cyc1("t1_hit", 1, 0, 1);
    pix(20, 9, 1);  cyc1("t1_left", 0, 0, 1);
    pix(36, 10, 1); cyc1("t1_below", 0, 0, 1);
    pix(35, 25, 1); cyc1("t1_corner", 1, 0, 1);

    // Orientation: offset r=1, c=2, img_sel=5, ROM returns addr[1:0]
    pix(0, 0, 0); cyc1("t2_idle", 0, 0, 0);
    rom_mode[0] = 1'b1;
    prev_addr = 12'h0FF;
    for (int k = 0; k < 5; k++) begin
      set_ch(0, 8'd10, 8'd20, t2_info[k]);
      frame_start = 1'b1; pix(0, 0, 0); cyc1("t2_load", 0, 0, 0);
      frame_start = 1'b0;
      check("t2_hold", 64'(rom_addr[11:0]), 64'(prev_addr));
      pix(21, 12, 1); cyc1("t2_pix", t2_icon[k], 0, 1);
      check("t2_addr", 64'(rom_addr[11:0]), 64'(t2_addr[k]));
      prev_addr = t2_addr[k];
    end

    // Priority and transparency between channels 0 and 2
    pix(0, 0, 0); cyc1("t3_idle", 0, 0, 0);
    rom_mode[0] = 1'b0; rom_const[0] = 2'd3; rom_const[2] = 2'd2;
    set_ch(0, 8'd40, 8'd30, 8'h80);
    set_ch(2, 8'd40, 8'd30, 8'h80);
    frame_start = 1'b1; cyc1("t3_load", 0, 0, 0);
    frame_start = 1'b0;
    pix(30, 40, 1); cyc1("t3_ch0", 3, 0, 1);
    pix(0, 0, 0);   cyc1("t3_gap", 0, 0, 0);
    rom_const[0] = 2'd0;
    pix(31, 41, 1); cyc1("t3_ch2", 2, 2, 1);
    pix(0, 0, 0);   cyc1("t3_gap2", 0, 0, 0);
    set_ch(0, 8'd40, 8'd30, 8'h00);
    set_ch(2, 8'd40, 8'd30, 8'h00);
    frame_start = 1'b1; cyc1("t3_off_load", 0, 0, 0);
    frame_start = 1'b0;
    pix(30, 40, 1); cyc1("t3_off", 0, 0, 1);

    // Double-buffered position
    pix(0, 0, 0); cyc1("t4_idle", 0, 0, 0);
    rom_const[0] = 2'd1;
    set_ch(0, 8'd10, 8'd20, 8'h80);
    frame_start = 1'b1; cyc1("t4_load", 0, 0, 0);
    frame_start = 1'b0;
    set_ch(0, 8'd50, 8'd20, 8'h80);
    pix(20, 10, 1); cyc1("t4_old", 1, 0, 1);
    pix(20, 50, 1); cyc1("t4_nonew", 0, 0, 1);
    frame_start = 1'b1;
    pix(20, 10, 1); cyc1("t4_fs_edge", 1, 0, 1);
    frame_start = 1'b0;
    pix(20, 50, 1); cyc1("t4_new", 1, 0, 1);
    pix(20, 10, 1); cyc1("t4_oldgone", 0, 0, 1);

    // pix_valid gating and right-edge clipping (second DUT uses LOC_SHIFT=2)
    pix(20, 50, 0); cyc1("t5_pixinv", 0, 0, 0);
    set_ch(0, 8'd255, 8'd0, 8'h80);
    frame_start = 1'b1; pix(0, 0, 0); cyc("t5_load", 0, 0, 0, 1, 0, 0);
    frame_start = 1'b0;
    pix(0, 1020, 1); cyc("t5_1020", 0, 0, 1, 1, 1, 1);
    pix(0, 1023, 1); cyc("t5_1023", 0, 0, 1, 1, 1, 1);
    pix(0, 0, 1);    cyc("t5_col0", 0, 0, 1, 1, 0, 1);
    pix(0, 1019, 1); cyc("t5_1019", 0, 0, 1, 1, 0, 1);
    pix(15, 1023, 1); cyc("t5_r15", 0, 0, 1, 1, 1, 1);
    pix(16, 1020, 1); cyc("t5_r16", 0, 0, 1, 1, 0, 1);
    pix(0, 1020, 0); cyc("t5_inv", 0, 0, 0, 1, 0, 0);
    pix(0, 255, 1);  cyc("t5_main255", 1, 0, 1, 1, 0, 1);

    // Asynchronous reset mid-stream
    pix(0, 255, 1);
    repeat (4) cyc1("t6_pre", 1, 0, 1);
    reset = 1'b0;
    #1;
    check("t6_rst_icon", 64'(icon), 64'd0);
    check("t6_rst_id", 64'(icon_id), 64'd0);
    check("t6_rst_valid", 64'(icon_valid), 64'd0);
    check("t6_rst_addr", 64'(rom_addr), 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) cyc1("t6_dis", 0, 0, 1);
    frame_start = 1'b1; cyc1("t6_fs", 0, 0, 1);
    frame_start = 1'b0; cyc1("t6_back", 1, 0, 1);
    pix(0, 0, 0);
    repeat (3) cyc1("flush", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icon_compositor.md
Name: icon_compositor

Overview:
- Parametrised successor to the single-icon pixel generator: overlays NUM_ICONS 2^DIM_LOG2-square icons on the VGA raster.
- Each icon has its own position, image select and orientation (mirror/transpose).
- Per-icon ROM ports are provided, and icons resolve by fixed priority.
- Sits between the pixel counters (Rowpx/Colpx) and the colorizer; fixed 3-cycle pipeline with a matching valid output.
- Positions are double-buffered and only take effect on a frame-start pulse, so icons never tear mid-frame.

Parameters:
- NUM_ICONS, 4, number of icon channels; channel 0 has highest priority.
- DIM_LOG2, 4, icon edge is 2^DIM_LOG2 pixels.
- LOC_W, 8, width of each LocX/LocY.
- LOC_SHIFT, 0, pixel position = Loc << LOC_SHIFT.
- PIX_W, 10, width of Rowpx/Colpx.
- IMG_W, 4, image-select bits per icon.
- COLOR_W, 2, icon colour code width; value 0 is transparent.
- ROM_AW, IMG_W+2*DIM_LOG2, derived ROM address width (localparam).

Ports:
- vga_clock  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at top of frame; loads shadow regs into active regs.
- LocX  in  NUM_ICONS*LOC_W  per-icon column location, channel i at [i*LOC_W +: LOC_W].
- LocY  in  NUM_ICONS*LOC_W  per-icon row location.
- Iconinfo  in  NUM_ICONS*(IMG_W+4)  per icon {enable, transpose, mirror_y, mirror_x, img_sel}.
- Rowpx, Colpx  in  PIX_W each  current raster coordinates.
- pix_valid  in  1  Rowpx/Colpx are in the visible area.
- rom_addr  out  NUM_ICONS*ROM_AW  registered per-channel ROM address.
- rom_data  in  NUM_ICONS*COLOR_W  per-channel ROM data; 1-cycle synchronous read latency.
- icon  out  COLOR_W  composited colour code; 0 means no icon.
- icon_id  out  clog2(NUM_ICONS) (min 1)  winning channel index.
- icon_valid  out  1  pix_valid delayed by 3 cycles.

Behaviour:
- Reset (reset==0, async): all active regs, pipeline regs and outputs go to 0.
  - All channels are therefore disabled; rom_addr=0, icon=0, icon_id=0, icon_valid=0.
  - Shadow regs are the live input ports and are not stored.
- Frame-start load: on a clock edge with frame_start=1, active {LocX, LocY, Iconinfo} <= inputs.
  - A pixel sampled on that same edge uses the OLD active values.
  - Inputs that change while frame_start=0 have no effect.
- Stage 1 (edge k+1, per channel i):
  - dr = Rowpx - (LocY_i<<LOC_SHIFT) and dc = Colpx - (LocX_i<<LOC_SHIFT), in PIX_W+1-bit signed arithmetic; no wrap aliasing.
  - hit_i = enable_i & pix_valid & 0<=dr<2^DIM & 0<=dc<2^DIM.
  - Orientation, applied in order:
    - r = dr[DIM-1:0] and c = dc[DIM-1:0];
    - if mirror_x, c = ~c;
    - if mirror_y, r = ~r;
    - if transpose, swap r and c.
  - rom_addr_i <= {img_sel_i, r, c}.
  - When hit_i=0, rom_addr_i holds its previous value (power saving); data is ignored.
- Stage 2 (edge k+2): the ROM registers data; hit_i and pix_valid are delayed one stage.
- Stage 3 (edge k+3): winner = lowest i with hit_i & rom_data_i != 0.
  - If a winner exists: icon <= rom_data_winner, icon_id <= winner.
  - Otherwise icon <= 0 and icon_id <= 0.
  - icon_valid <= delayed pix_valid.
- Latency: exactly 3 vga_clock edges from Rowpx/Colpx sample to icon. Throughput is 1 pixel/cycle with no stalls.
- Transparent pixels (data 0) of a higher-priority icon reveal lower-priority icons.
- pix_valid=0 forces all hit_i=0, so icon=0 three cycles later.
- Icon partially off-screen (Loc near max) is clipped naturally; no wrap to column 0.
- Reset mid-frame clears the pipeline immediately; the first valid output comes 3 edges after release.

Decomposition:
- Shared package icon_pkg:
  - iconinfo field offsets (EN, TR, MY, MX, IMG);
  - TRANSPARENT = 0;
  - function for clog2-min-1.
- One sub-module, icon_addr_gen: per-channel range check, orientation transform and stage-1 address/hit registers. It is instantiated NUM_ICONS times via generate.
- The top level holds the active regs, stage-2/3 delays and the priority encoder.

Test Plan:
1. Single icon, defaults; load LocX=10, LocY=20 via frame_start; ROM returns 2'b01 everywhere; raster pixel (20,10).
   - Expect icon=1 and icon_id=0 exactly 3 cycles later.
   - Pixels (20,9) and (36,10) give icon=0.
2. Orientation: ROM data = address[1:0] pattern, pixel offset (r=1, c=2).
   - mirror_x gives rom_addr col=13.
   - mirror_y gives row=14.
   - transpose gives {row=2, col=1}.
   - All three set gives {row=13, col=14}.
3. Priority/transparency: icons 0 and 2 overlap at the same Loc.
   - ch0 data=3 gives icon=3, id=0.
   - ch0 data=0 and ch2 data=2 gives icon=2, id=2.
   - Disabling both gives icon=0.
4. Double buffer: change LocX from 10 to 50 without frame_start → icon still at col 10. Pulse frame_start → icon at col 50 on the next sampled pixel. The pixel sampled on the frame_start edge still uses 10.
5. Edges: LocX=255 with LOC_SHIFT=2 gives x=1020; columns 1020..1023 hit and column 0 does not. pix_valid=0 forces icon=0 and icon_valid=0.
6. Assert reset low mid-stream → outputs 0 asynchronously, before the next edge. After release, all channels are disabled until the next frame_start.
